// File: rtl/ahb_ext_sram_pkg.sv
// Shared AHB-Lite encodings used by the external-port SRAM subordinate.
package ahb_ext_sram_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ram1p1rwbe_ext.sv
// DEPTH x WIDTH synchronous-read memory with byte-enable writes; read port holds its word until the next read.
module ram1p1rwbe_ext
    import ahb_ext_sram_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     ren_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [WIDTH/8-1:0]       wstrb_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Array contents survive reset; only the output register is cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (wstrb_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)    rdata_q <= '0;
        else if (ren_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_ext_sram.sv
// AHB-Lite subordinate SRAM on the external port with programmable wait states and ERROR responses.
module ahb_ext_sram
    import ahb_ext_sram_pkg::*;
#(
    parameter int                 AHBW        = 64,
    parameter int                 PA_BITS     = 56,
    parameter logic [PA_BITS-1:0] BASE        = 'h8000_0000,
    parameter int                 DEPTH       = 4096,
    parameter int                 WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               HSELEXT,
    input  logic [PA_BITS-1:0] HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic               HREADY,
    input  logic [AHBW-1:0]    HWDATA,
    input  logic [AHBW/8-1:0]  HWSTRB,
    output logic [AHBW-1:0]    HRDATAEXT,
    output logic               HREADYEXT,
    output logic               HRESPEXT
);

    localparam int                 NB      = AHBW/8;
    localparam int                 LOG2B   = $clog2(NB);
    localparam int                 AW      = $clog2(DEPTH);
    localparam logic [PA_BITS-1:0] LIMIT   = PA_BITS'(DEPTH*NB);
    localparam logic [2:0]         MAXSIZE = 3'(LOG2B);
    localparam logic [2:0]         WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} statetype;

    statetype           state_q;
    logic [2:0]         cnt_q;
    logic [AW-1:0]      idx_q;
    logic               write_q, ready_q, resp_q;
    logic [PA_BITS-1:0] off;
    logic [LOG2B-1:0]   amask;
    logic               accept, err_a, take, enter_data, ren, we, fwd_hit;
    logic [AW-1:0]      idx_a, ridx;
    logic [AHBW-1:0]    ram_rdata, merged, fwd_wdata_q;
    logic [NB-1:0]      fwd_strb_q;
    logic               fwd_q;

    always_comb begin
        off        = HADDR - BASE;
        amask      = ~({LOG2B{1'b1}} << HSIZE);
        err_a      = (off >= LIMIT) || (HSIZE > MAXSIZE) || (|(HADDR[LOG2B-1:0] & amask));
        idx_a      = off[LOG2B +: AW];
        accept     = HSELEXT && HREADY && (htrans_t'(HTRANS) inside {HT_NONSEQ, HT_SEQ});
        take       = accept && (state_q inside {S_IDLE, S_DATA, S_ERR2});
        enter_data = (take && !err_a && (WAIT_STATES == 0)) || (state_q == S_WAIT && cnt_q == 3'd0);
        ridx       = (state_q == S_WAIT) ? idx_q : idx_a;
        ren        = enter_data && !((state_q == S_WAIT) ? write_q : HWRITE);
        we         = (state_q == S_DATA) && write_q && !reset;
        fwd_hit    = we && (idx_q == ridx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= S_DATA;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_ERR1: begin
                    state_q <= S_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= HRESP_ERROR;
                end
                default: begin
                    // IDLE, DATA and ERR2 all end a data phase, so each can take a new address phase.
                    if (take) begin
                        idx_q   <= idx_a;
                        write_q <= HWRITE;
                        if (err_a) begin
                            state_q <= S_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= WS_INIT;
                            ready_q <= 1'b0;
                            resp_q  <= HRESP_OKAY;
                        end else begin
                            state_q <= S_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= HRESP_OKAY;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // The RAM returns the pre-write word when a write lands on the read edge; patch in the written lanes.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_q       <= 1'b0;
            fwd_wdata_q <= '0;
            fwd_strb_q  <= '0;
        end else if (ren) begin
            fwd_q       <= fwd_hit;
            fwd_wdata_q <= HWDATA;
            fwd_strb_q  <= HWSTRB;
        end
    end

    always_comb begin
        merged = ram_rdata;
        for (int b = 0; b < NB; b++) begin
            if (fwd_strb_q[b]) merged[b*8 +: 8] = fwd_wdata_q[b*8 +: 8];
        end
    end

    ram1p1rwbe_ext #(.DEPTH(DEPTH), .WIDTH(AHBW)) u_ram (
        .clk_i   (clk),
        .reset_i (reset),
        .ren_i   (ren),
        .raddr_i (ridx),
        .we_i    (we),
        .waddr_i (idx_q),
        .wdata_i (HWDATA),
        .wstrb_i (HWSTRB),
        .rdata_o (ram_rdata)
    );

    assign HRDATAEXT = fwd_q ? merged : ram_rdata;
    assign HREADYEXT = ready_q;
    assign HRESPEXT  = resp_q;

endmodule

// File: tb/tb_ahb_ext_sram.sv
// Three SRAM subordinates (0, 3 and 4 wait states) on one AHB bus, checked against a byte-level memory model.
module tb_ahb_ext_sram;
    import ahb_ext_sram_pkg::*;

    localparam logic [55:0] BASE  = 56'h8000_0000;
    localparam int          DEPTH = 4096;

    typedef struct {
        int          kind;   // 0 real transfer, 1 BUSY, 2 unselected NONSEQ
        logic        seq;
        logic [55:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [63:0] data;
        logic [7:0]  strb;
    } tx_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  hsel;
    logic [55:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic [63:0] hwdata;
    logic [7:0]  hwstrb;
    logic [63:0] rdat [3];
    logic        rdy  [3];
    logic        rsp  [3];
    int          act = 0;

    int          ws [3] = '{0, 3, 4};
    logic [63:0] mdl [3][DEPTH];
    logic [7:0]  bv  [3][DEPTH];
    tx_t         txq [$];
    int          n_chk = 0, n_pass = 0, n_fail = 0;

    always #5 clk = ~clk;
    assign hready = rdy[act];

    ahb_ext_sram #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .HSELEXT(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HRDATAEXT(rdat[0]), .HREADYEXT(rdy[0]), .HRESPEXT(rsp[0]));
    ahb_ext_sram #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .HSELEXT(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HRDATAEXT(rdat[1]), .HREADYEXT(rdy[1]), .HRESPEXT(rsp[1]));
    ahb_ext_sram #(.WAIT_STATES(4)) u_ws4 (
        .clk(clk), .reset(reset), .HSELEXT(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HRDATAEXT(rdat[2]), .HREADYEXT(rdy[2]), .HRESPEXT(rsp[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [55:0] a, input logic [2:0] s);
        if (a < BASE) return 1'b1;
        if ((a - BASE) >= 56'(DEPTH*8)) return 1'b1;
        if (s > 3'd3) return 1'b1;
        if ((a % (56'd1 << s)) != 56'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_lows(input tx_t t, input int d);
        if (t.kind != 0) return 0;
        return is_err(t.addr, t.size) ? 1 : ws[d];
    endfunction

    task automatic add(input int kind, input logic [55:0] a, input logic wr, input logic [2:0] sz,
                       input logic [63:0] dat, input logic [7:0] st);
        tx_t t;
        t.kind = kind; t.seq = 1'b0; t.addr = a; t.wr = wr; t.size = sz; t.data = dat; t.strb = st;
        txq.push_back(t);
    endtask

    task automatic drive_addr(input int d, input int i);
        tx_t t;
        if (i < txq.size()) begin
            t      = txq[i];
            hsel   = (t.kind == 2) ? 3'b000 : (3'b001 << d);
            htrans = (t.kind == 1) ? HT_BUSY : (t.seq ? HT_SEQ : HT_NONSEQ);
            haddr  = t.addr;
            hwrite = t.wr;
            hsize  = t.size;
        end else begin
            hsel = 3'b000; htrans = HT_IDLE; haddr = '0; hwrite = 1'b0; hsize = 3'd0;
        end
    endtask

    // Runs txq back to back on subordinate d, starting just after a posedge with the bus idle.
    task automatic run(input int d);
        int          i, pend, lows, cyc, exp_cyc, w;
        logic        r, rs, e;
        logic [63:0] rd, m;
        tx_t         t;
        i = 0; pend = -1; lows = 0; cyc = 0; exp_cyc = 1;
        foreach (txq[k]) exp_cyc += exp_lows(txq[k], d) + 1;
        drive_addr(d, 0);
        while ((pend >= 0 || i < txq.size()) && cyc < exp_cyc + 20) begin
            @(negedge clk);
            cyc++;
            r = rdy[d]; rs = rsp[d]; rd = rdat[d];
            if (pend >= 0) begin
                t = txq[pend];
                e = (t.kind == 0) && is_err(t.addr, t.size);
                check("hresp", 64'(rs), 64'(e));
                if (!r) lows++;
                else begin
                    check("wait_cycles", 64'(lows), 64'(exp_lows(t, d)));
                    if (t.kind == 0 && !e) begin
                        w = int'((t.addr - BASE) >> 3);
                        if (t.wr) begin
                            for (int b = 0; b < 8; b++) if (t.strb[b]) begin
                                mdl[d][w][b*8 +: 8] = t.data[b*8 +: 8];
                                bv[d][w][b] = 1'b1;
                            end
                        end else begin
                            for (int b = 0; b < 8; b++) m[b*8 +: 8] = bv[d][w][b] ? 8'hFF : 8'h00;
                            check("hrdata", rd & m, mdl[d][w] & m);
                        end
                    end
                end
            end else begin
                check("idle_ready", 64'(r), 64'd1);
                check("idle_resp", 64'(rs), 64'd0);
            end
            @(posedge clk);
            #1;
            if (r) begin
                pend   = (i < txq.size()) ? i : -1;
                lows   = 0;
                hwdata = (pend >= 0) ? txq[pend].data : 64'd0;
                hwstrb = (pend >= 0) ? txq[pend].strb : 8'd0;
                if (i < txq.size()) i++;
                drive_addr(d, i);
            end
        end
        check("pipeline_cycles", 64'(cyc), 64'(exp_cyc));
        txq.delete();
    endtask

    task automatic gen_random(input int n);
        tx_t t;
        int  wi, off;
        for (int k = 0; k < n; k++) begin
            t.kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            t.size = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) t.size = 3'($urandom_range(4, 7));
            wi  = int'($urandom_range(0, 15));
            off = (t.size > 3'd3) ? 0 : ((int'($urandom_range(0, 7)) >> t.size) << t.size);
            if ($urandom_range(0, 9) == 0 && t.size != 3'd0 && t.size <= 3'd3) off += 1;
            t.addr = BASE + 56'(wi*8 + off);
            case ($urandom_range(0, 11))
                0: t.addr = BASE + 56'(DEPTH*8) + 56'(wi*8);
                1: t.addr = BASE - 56'd8;
                default: ;
            endcase
            t.seq  = 1'($urandom_range(0, 1));
            t.wr   = 1'($urandom_range(0, 1));
            t.data = {$urandom, $urandom};
            t.strb = 8'($urandom_range(0, 255));
            txq.push_back(t);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) for (int w = 0; w < DEPTH; w++) begin
            bv[d][w] = 8'h00; mdl[d][w] = 64'd0;
        end
        reset = 1'b1; hsel = 3'b000; haddr = '0; htrans = HT_IDLE; hwrite = 1'b0;
        hsize = 3'd0; hwdata = '0; hwstrb = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_ready", 64'(rdy[d]), 64'd1);
            check("reset_resp", 64'(rsp[d]), 64'd0);
            check("reset_rdata", rdat[d], 64'd0);
        end
        @(posedge clk); #1;

        act = 0;
        add(0, BASE + 56'd8, 1'b1, 3'd3, 64'h1122334455667788, 8'hFF);
        add(0, BASE + 56'd8, 1'b0, 3'd3, 64'd0, 8'h00);
        run(0);

        act = 1;
        add(0, BASE, 1'b1, 3'd3, 64'hCAFEF00D12345678, 8'hFF);
        add(0, BASE, 1'b0, 3'd3, 64'd0, 8'h00);
        run(1);

        act = 0;
        add(0, BASE, 1'b1, 3'd3, 64'd0, 8'hFF);
        add(0, BASE + 56'd2, 1'b1, 3'd0, 64'h0000_0000_00AB_0000, 8'h04);
        add(0, BASE, 1'b0, 3'd3, 64'd0, 8'h00);
        run(0);

        add(0, BASE + 56'(DEPTH*8), 1'b0, 3'd3, 64'd0, 8'h00);
        add(0, BASE, 1'b0, 3'd3, 64'd0, 8'h00);
        run(0);

        add(0, BASE + 56'd16, 1'b1, 3'd3, 64'h0000_0000_0000_DEAD, 8'hFF);
        add(0, BASE + 56'd16, 1'b0, 3'd3, 64'd0, 8'h00);
        run(0);

        act = 2;
        add(0, BASE + 56'd24, 1'b1, 3'd3, 64'h0123456789ABCDEF, 8'hFF);
        add(0, BASE + 56'd24, 1'b0, 3'd3, 64'd0, 8'h00);
        run(2);
        hsel = 3'b100; htrans = HT_NONSEQ; haddr = BASE + 56'd24; hwrite = 1'b1; hsize = 3'd3;
        @(posedge clk); #1;
        hsel = 3'b000; htrans = HT_IDLE; hwdata = 64'hFFFF_FFFF_FFFF_FFFF; hwstrb = 8'hFF;
        @(negedge clk);
        check("ws4_stall", 64'(rdy[2]), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; hwdata = '0; hwstrb = '0;
        @(negedge clk);
        check("midreset_ready", 64'(rdy[2]), 64'd1);
        check("midreset_resp", 64'(rsp[2]), 64'd0);
        check("midreset_rdata", rdat[2], 64'd0);
        @(posedge clk); #1;
        add(0, BASE + 56'd24, 1'b0, 3'd3, 64'd0, 8'h00);
        run(2);

        for (int d = 0; d < 3; d++) begin
            act = d;
            repeat (3) begin
                gen_random(14);
                run(d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
